// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory behind a valid/ready request port with a fixed response latency.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects requests whose byte address is not word aligned.
module mips_dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // LATENCY=1 skips WAIT entirely, so the load value is irrelevant there.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          misalign;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic          unused_addr;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && (state == S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign    = |req_addr[1:0];
    assign unused_addr = ^req_addr[31:AW+2];
`else
    assign misalign    = 1'b0;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // The write commits on the edge that enters RESP; with LATENCY=1 that is the accepting edge,
    // before the request fields have been captured.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_data = wdata_q;
        if (LATENCY == 1) begin
            if (accept && req_we && !misalign) begin
                wr_en   = 1'b1;
                wr_idx  = req_addr[AW+1:2];
                wr_data = req_wdata;
            end
        end else if ((state == S_WAIT) && (cnt == 4'd0) && we_q && !err_q) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            // NOTE: the storage array is cleared by reset, so it maps to resettable flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        err_q   <= misalign;
                        cnt     <= CNT_LOAD;
                        state   <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = (state == S_RESP);
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? mem[idx_q] : 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
    assign resp_err = resp_valid && err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: a LATENCY=2 instance with a response monitor,
// plus a LATENCY=1 instance for single-cycle back-to-back behaviour.
module tb_mips_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        d1_req_valid, d1_req_ready, d1_req_we;
    logic [31:0] d1_req_addr, d1_req_wdata;
    logic        d1_resp_valid, d1_resp_err;
    logic [31:0] d1_resp_rdata;

    int   checks     = 0;
    int   failures   = 0;
    int   resp_count = 0;
    bit   mon_en     = 1'b0;
    exp_t sb_q[$];

    mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_we(d1_req_we),
        .req_addr(d1_req_addr), .req_wdata(d1_req_wdata),
        .resp_valid(d1_resp_valid), .resp_rdata(d1_resp_rdata), .resp_err(d1_resp_err)
    );

    // Response monitor: pops the scoreboard on every pulse, and checks outputs are zero otherwise.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            checks++;
            if (resp_valid === 1'b1) begin
                resp_count++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: resp_valid=1 rdata=%h with no outstanding request", resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                        failures++;
                        $display("FAIL resp_data: got rdata=%h err=%b expected rdata=%h err=%b",
                                 resp_rdata, resp_err, e.rdata, e.err);
                    end
                end
            end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
                failures++;
                $display("FAIL idle_outputs: got rdata=%h err=%b expected 0 and 0", resp_rdata, resp_err);
            end
        end
    end

    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != LATENCY) begin
            failures++;
            $display("FAIL latency: response after %0d cycles, expected %0d", n, LATENCY);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        d1_req_valid = 1'b0; d1_req_we = 1'b0; d1_req_addr = 32'd0; d1_req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (d1_req_ready !== 1'b1 || d1_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_l1: got ready=%b valid=%b expected 1 0", d1_req_ready, d1_resp_valid);
        end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        transact(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        transact(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        transact(1'b0, 32'h44, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   acc;
        int   base;
        int   n;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        acc  = 0;
        base = resp_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        e.rdata = 32'hDEADBEEF;
        e.err   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) begin
                sb_q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (resp_count - base != acc) begin
            failures++;
            $display("FAIL b2b_resp_count: got %0d responses expected %0d", resp_count - base, acc);
        end
        checks++;
        if (acc != (20 + LATENCY) / (LATENCY + 1)) begin
            failures++;
            $display("FAIL b2b_accept_count: got %0d acceptances expected %0d", acc, (20 + LATENCY) / (LATENCY + 1));
        end
    endtask

    task automatic test_wrap();
        transact(1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0);
        transact(1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    endtask

    task automatic test_latency1();
        @(posedge clk); #1;
        d1_req_valid = 1'b1; d1_req_we = 1'b0; d1_req_addr = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (d1_resp_valid !== 1'b1 || d1_resp_rdata !== 32'd0 || d1_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL l1_first: got valid=%b rdata=%h ready=%b expected 1 0 0", d1_resp_valid, d1_resp_rdata, d1_req_ready);
        end
        d1_req_addr = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (d1_req_ready !== 1'b1 || d1_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL l1_gap: got ready=%b valid=%b expected 1 0", d1_req_ready, d1_resp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (d1_resp_valid !== 1'b1 || d1_resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL l1_second: got valid=%b rdata=%h expected 1 0", d1_resp_valid, d1_resp_rdata);
        end
        d1_req_we = 1'b1; d1_req_addr = 32'h8; d1_req_wdata = 32'h13579BDF;
        @(posedge clk); #1;
        d1_req_valid = 1'b1;
        @(posedge clk); #1;
        d1_req_valid = 1'b0;
        checks++;
        if (d1_resp_valid !== 1'b1 || d1_resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL l1_write: got valid=%b rdata=%h expected 1 0", d1_resp_valid, d1_resp_rdata);
        end
        @(posedge clk); #1;
        d1_req_valid = 1'b1; d1_req_we = 1'b0;
        @(posedge clk); #1;
        d1_req_valid = 1'b0;
        checks++;
        if (d1_resp_valid !== 1'b1 || d1_resp_rdata !== 32'h13579BDF) begin
            failures++;
            $display("FAIL l1_readback: got valid=%b rdata=%h expected 1 13579bdf", d1_resp_valid, d1_resp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_wait: got ready=%b valid=%b expected 0 0", req_ready, resp_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_resp: got %0d response pulses expected 0", seen);
        end
        transact(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_priority();
        int seen;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_priority_ready: got %b expected 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_priority_resp: got %0d response pulses expected 0", seen);
        end
    endtask

    task automatic test_align();
        transact(1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, ALIGN);
        transact(1'b0, 32'h20, 32'h0, ALIGN ? 32'h0 : 32'hFFFFFFFF, 1'b0);
    endtask

    initial begin
        int n;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wrap();
        test_latency1();
        test_reset_abort();
        test_reset_priority();
        test_align();
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_dmem_responder.md
MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (a power of two, 4..4096).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the processor presents a data-memory request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write (MemWrite), 0 = read (MemRead).
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address from the ALU result.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data (rt register value).
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle pulse marking completion.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits: load data, valid when resp_valid=1 and the request was a read.
REQ-012 The block SHALL have port resp_err, output, 1 bit: request rejected, qualified by resp_valid.

Function
REQ-013 Handshake: a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata are captured on that edge.
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Transitions: IDLE->WAIT on acceptance when LATENCY>1; IDLE->RESP on acceptance when LATENCY=1; WAIT->RESP when the down-counter reaches 0; RESP->IDLE unconditionally.
REQ-016 The down-counter SHALL load LATENCY-2 on acceptance and decrement once per WAIT cycle, so resp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-017 resp_valid SHALL be 1 only in RESP, for exactly one cycle; a back-to-back request is accepted no earlier than the cycle after RESP.
REQ-018 The word index SHALL be captured address bits [log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-019 A write SHALL update the addressed word on the RESP-entry edge; resp_rdata for a write response SHALL be 0.
REQ-020 A read SHALL drive resp_rdata with the addressed word as of the RESP cycle, including any earlier completed write to it.
REQ-021 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-022 req_valid asserted while req_ready=0 SHALL be ignored; no request is queued.

Reset
REQ-023 rst=1 on a rising edge SHALL force IDLE, counter 0, req_ready=1 on the following cycle, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-024 Reset SHALL clear every memory word to 0.
REQ-025 A reset during WAIT or RESP SHALL abort the transaction: no response pulse and no write commit.
REQ-026 Reset SHALL take priority over a simultaneous request; that request is not accepted.

Configuration
REQ-027 Macro DMEM_ALIGN_CHECK_EN defined: a request with req_addr[1:0]!=0 SHALL complete with normal latency and resp_err=1, perform no write and return resp_rdata=0.
REQ-028 Macro DMEM_ALIGN_CHECK_EN undefined: req_addr[1:0] SHALL be ignored, resp_err SHALL be tied to 0, and logic is otherwise identical.

Verification
REQ-029 Reset, then write 0xDEADBEEF to 0x10 and read 0x10 with LATENCY=2 -> each resp_valid exactly 2 cycles after acceptance; read returns 0xDEADBEEF.
REQ-030 LATENCY=1: back-to-back reads of 0x0 and 0x4 after reset -> req_ready low for 1 cycle between them; both return 0x00000000.
REQ-031 DEPTH=256: write 0x12345678 to 0x400, then read 0x0 -> wrap returns 0x12345678.
REQ-032 Assert rst during WAIT of a write of 0xA5A5A5A5 to 0x20 -> no resp_valid; a later read of 0x20 returns 0x0.
REQ-033 DMEM_ALIGN_CHECK_EN defined: write 0xFFFFFFFF to 0x22 -> resp_err=1; a read of 0x20 returns 0x0. Undefined: the same write lands at word 0x20 and resp_err=0.
REQ-034 Hold req_valid high while busy -> exactly one acceptance per IDLE cycle; the response count equals the acceptance count.
